// File: rtl/pipe_pkg.sv
// Shared streaming-pipeline types: skid buffer state encoding and occupancy helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] state_count(input skid_state_e s);
    logic [1:0] v_count;
    case (s)
      BUSY:    v_count = 2'd1;
      FULL:    v_count = 2'd2;
      default: v_count = 2'd0;
    endcase
    return v_count;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry ready/valid register slice: main register drives the output and the skid
// register absorbs the one word in flight when downstream stalls. All outputs are registered.
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [1:0]            count_o
);

  skid_state_e           r_state;
  skid_state_e           w_state_next;
  logic                  r_s_ready;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_m_valid;
  logic [1:0]            w_count;
  logic                  w_in;
  logic                  w_out;

  assign w_in  = s_valid_i & r_s_ready;
  assign w_out = w_m_valid & m_ready_i;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= EMPTY;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // Ready is registered from the next state, so it never depends combinationally on m_ready_i.
      r_s_ready <= (w_state_next != FULL);
    end
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: if (w_in) w_state_next = BUSY;
      BUSY: begin
        if (w_in && !w_out)      w_state_next = FULL;
        else if (w_out && !w_in) w_state_next = EMPTY;
      end
      FULL:    if (w_out) w_state_next = BUSY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_comb begin
    w_m_valid = (r_state != EMPTY);
    w_count   = state_count(r_state);
  end

  // NOTE: both data registers are reset; only r_main is visible, but clearing r_skid keeps state deterministic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_in) r_main <= s_data_i;
        BUSY: begin
          if (w_in && w_out) r_main <= s_data_i;
          else if (w_in)     r_skid <= s_data_i;
        end
        FULL:    if (w_out) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  assign s_ready_o = r_s_ready;
  assign m_valid_o = w_m_valid;
  assign m_data_o  = r_main;
  assign count_o   = w_count;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer: vector table for streaming/backpressure/stall,
// hand sequences for reset release and asynchronous reset while full.
module tb_skid_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_data_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic [1:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  skid_buffer #(.DATA_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .count_o   (count_o)
  );

  typedef struct {
    logic        s_valid;
    logic [31:0] s_data;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    logic [31:0] exp_m_data;
    logic [1:0]  exp_count;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic vld,
                            input logic [1:0] cnt);
    check({tag, " s_ready"}, {31'd0, s_ready_o}, {31'd0, rdy});
    check({tag, " m_valid"}, {31'd0, m_valid_o}, {31'd0, vld});
    check({tag, " count"},   {30'd0, count_o},   {30'd0, cnt});
  endtask

  function automatic vec_t mk(input logic sv, input logic [31:0] d, input logic mr,
                              input logic rdy, input logic vld, input logic [31:0] md,
                              input logic [1:0] cnt);
    vec_t v;
    v.s_valid = sv; v.s_data = d; v.m_ready = mr;
    v.exp_s_ready = rdy; v.exp_m_valid = vld; v.exp_m_data = md; v.exp_count = cnt;
    return v;
  endfunction

  initial begin
    // Inputs applied for one cycle; expectations observed at the following negedge.
    // Streaming, no bubbles
    vecs[0]  = mk(1, 32'hAAAA0000, 1, 1, 1, 32'hAAAA0000, 2'd1);
    vecs[1]  = mk(1, 32'hAAAA0001, 1, 1, 1, 32'hAAAA0001, 2'd1);
    vecs[2]  = mk(1, 32'hAAAA0002, 1, 1, 1, 32'hAAAA0002, 2'd1);
    vecs[3]  = mk(1, 32'hAAAA0003, 1, 1, 1, 32'hAAAA0003, 2'd1);
    vecs[4]  = mk(0, 32'h0,        1, 1, 0, 32'h0,        2'd0);
    // Backpressure: fill, third word held upstream, then drain in order
    vecs[5]  = mk(1, 32'hBBBB0000, 0, 1, 1, 32'hBBBB0000, 2'd1);
    vecs[6]  = mk(1, 32'hBBBB0001, 0, 0, 1, 32'hBBBB0000, 2'd2);
    vecs[7]  = mk(1, 32'hBBBB0002, 0, 0, 1, 32'hBBBB0000, 2'd2);
    vecs[8]  = mk(1, 32'hBBBB0002, 1, 1, 1, 32'hBBBB0001, 2'd1);
    vecs[9]  = mk(1, 32'hBBBB0002, 1, 1, 1, 32'hBBBB0002, 2'd1);
    vecs[10] = mk(0, 32'h0,        1, 1, 0, 32'h0,        2'd0);
    // Stall hold
    vecs[11] = mk(1, 32'hCAFE0001, 0, 1, 1, 32'hCAFE0001, 2'd1);
    vecs[12] = mk(0, 32'h0,        0, 1, 1, 32'hCAFE0001, 2'd1);
    vecs[13] = mk(0, 32'h0,        0, 1, 1, 32'hCAFE0001, 2'd1);
    vecs[14] = mk(0, 32'h0,        0, 1, 1, 32'hCAFE0001, 2'd1);
    vecs[15] = mk(0, 32'h0,        0, 1, 1, 32'hCAFE0001, 2'd1);
    // Simultaneous in/out in BUSY, then m_ready ignored in EMPTY
    vecs[16] = mk(0, 32'h0,        1, 1, 0, 32'h0,        2'd0);
    vecs[17] = mk(1, 32'h1,        0, 1, 1, 32'h1,        2'd1);
    vecs[18] = mk(1, 32'h2,        1, 1, 1, 32'h2,        2'd1);
    vecs[19] = mk(0, 32'h0,        1, 1, 0, 32'h0,        2'd0);
    vecs[20] = mk(0, 32'h0,        1, 1, 0, 32'h0,        2'd0);

    // Reset with s_valid high
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'h1234_5678; m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_outs($sformatf("rst[%0d]", i), 1'b0, 1'b0, 2'd0);
    end
    rst_i = 1'b0;
    #1 check("release s_ready before edge", {31'd0, s_ready_o}, 32'd0);
    @(negedge clk_i);
    check_outs("release+1", 1'b1, 1'b0, 2'd0);
    s_valid_i = 1'b0;

    for (int i = 0; i < 21; i++) begin
      s_valid_i = vecs[i].s_valid;
      s_data_i  = vecs[i].s_data;
      m_ready_i = vecs[i].m_ready;
      @(negedge clk_i);
      check_outs($sformatf("vec[%0d]", i), vecs[i].exp_s_ready, vecs[i].exp_m_valid,
                 vecs[i].exp_count);
      if (vecs[i].exp_m_valid)
        check($sformatf("vec[%0d] m_data", i), m_data_o, vecs[i].exp_m_data);
    end

    // Fill with D0/D1, then assert reset between edges
    s_valid_i = 1'b1; s_data_i = 32'hD0; m_ready_i = 1'b0;
    @(negedge clk_i);
    s_data_i = 32'hD1;
    @(negedge clk_i);
    check_outs("full D0/D1", 1'b0, 1'b1, 2'd2);
    check("full D0/D1 m_data", m_data_o, 32'hD0);
    #2 rst_i = 1'b1;
    #1;
    check_outs("async rst", 1'b0, 1'b0, 2'd0);
    check("async rst m_data", m_data_o, 32'h0);
    s_valid_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("post-rst no D word[%0d]", i), {31'd0, m_valid_o}, 32'd0);
    end
    s_valid_i = 1'b1; s_data_i = 32'hE0;
    @(negedge clk_i);
    check_outs("post-rst E0", 1'b1, 1'b1, 2'd1);
    check("post-rst E0 m_data", m_data_o, 32'hE0);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    check_outs("post-rst drain", 1'b1, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
